imem_loader: RTL and testbench

- Writer side of the processor's instruction memory. The processor only reads the 128 x 16 instruction memory via PC.
- This block accepts a program as a valid/ready word stream and writes it into instruction memory.
- It verifies a trailing checksum and pads the unused words with HALT.
- It holds the processor in reset until a load completes successfully. It sits beside the processor top, between the host/test interface and the instruction memory write port.

---
 rtl/processor_pkg.sv | 25 ++
 rtl/imem_loader.sv | 164 ++++++++++++++++
 tb/tb_imem_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/processor_pkg.sv
// Shared processor definitions: loader FSM states, HALT pad word and opcodes.
package processor_pkg;

  // Pad value written into unused instruction words (opcode HALT, operand 0).
  localparam logic [15:0] HALT_WORD = 16'h5000;

  // Opcodes, also decoded by the ControlUnit.
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    FILL  = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } loader_state_e;

endpackage

// File: rtl/imem_loader.sv
// Instruction memory writer: streams a program into IMEM, checks a trailing
// checksum, pads the rest with HALT and releases the processor on success.
module imem_loader #(
  parameter int                 ADDR_W    = 7,
  parameter int                 DATA_W    = 16,
  parameter int                 DEPTH     = 128,
  parameter logic [DATA_W-1:0]  HALT_WORD = processor_pkg::HALT_WORD
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W:0]   Len,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              In_Valid,
  output logic              In_Ready,
  output logic              IM_Wr,
  output logic [ADDR_W-1:0] IM_Addr,
  output logic [DATA_W-1:0] IM_Data,
  output logic              CPU_Reset,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);
  import processor_pkg::*;

  // Count/length registers need one extra bit so a full-depth length fits.
  localparam int             CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] ADDR_TOP = CNT_W'(DEPTH - 1);

  loader_state_e     state_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] sum_d;
  logic              in_ready_q;
  logic              im_wr_q;
  logic [ADDR_W-1:0] im_addr_q;
  logic [DATA_W-1:0] im_data_q;
  logic              cpu_reset_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic              hs_s;
  logic              len_ok_s;
  logic              last_word_s;
  logic              full_len_s;
  logic              fill_last_s;
  logic              sum_match_s;

  assign In_Ready  = in_ready_q;
  assign IM_Wr     = im_wr_q;
  assign IM_Addr   = im_addr_q;
  assign IM_Data   = im_data_q;
  assign CPU_Reset = cpu_reset_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Err       = err_q;

  // Handshake, running checksum/count next values and the FSM decision terms.
  always_comb begin
    hs_s        = In_Valid && in_ready_q;
    sum_d       = sum_q + In_Data;
    count_d     = count_q + CNT_ONE;
    len_ok_s    = (Len != {CNT_W{1'b0}}) && (Len <= LEN_MAX);
    last_word_s = (count_q == (len_q - CNT_ONE));
    full_len_s  = (len_q == LEN_MAX);
    fill_last_s = (count_q == ADDR_TOP);
    sum_match_s = (In_Data == sum_q);
  end

  // Loader FSM with all outputs registered; IM_Wr is a one-cycle strobe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      len_q       <= {CNT_W{1'b0}};
      count_q     <= {CNT_W{1'b0}};
      sum_q       <= {DATA_W{1'b0}};
      in_ready_q  <= 1'b0;
      im_wr_q     <= 1'b0;
      im_addr_q   <= {ADDR_W{1'b0}};
      im_data_q   <= {DATA_W{1'b0}};
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      im_wr_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (Start) begin
            done_q      <= 1'b0;
            cpu_reset_q <= 1'b1;
            if (len_ok_s) begin
              len_q      <= Len;
              count_q    <= {CNT_W{1'b0}};
              sum_q      <= {DATA_W{1'b0}};
              err_q      <= 1'b0;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b1;
              state_q    <= LOAD;
            end else begin
              err_q   <= 1'b1;
              state_q <= ERROR;
            end
          end
        end
        LOAD: begin
          if (hs_s) begin
            im_wr_q   <= 1'b1;
            im_addr_q <= count_q[ADDR_W-1:0];
            im_data_q <= In_Data;
            sum_q     <= sum_d;
            count_q   <= count_d;
            if (last_word_s) begin
              state_q <= CHECK;
            end
          end
        end
        CHECK: begin
          // The checksum word is consumed here and never written to memory.
          if (hs_s) begin
            in_ready_q <= 1'b0;
            if (!sum_match_s) begin
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
              state_q <= ERROR;
            end else if (full_len_s) begin
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              cpu_reset_q <= 1'b0;
              state_q     <= DONE;
            end else begin
              state_q <= FILL;
            end
          end
        end
        FILL: begin
          // count_q already equals Len here, so it doubles as the pad address.
          im_wr_q   <= 1'b1;
          im_addr_q <= count_q[ADDR_W-1:0];
          im_data_q <= HALT_WORD;
          count_q   <= count_d;
          if (fill_last_s) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
            state_q     <= DONE;
          end
        end
        default: begin
          in_ready_q  <= 1'b0;
          busy_q      <= 1'b0;
          cpu_reset_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized program loads
// compared against a memory-image reference model.
module tb_imem_loader;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [7:0]  Len = 8'd0;
  logic [15:0] In_Data = 16'h0000;
  logic        In_Valid = 1'b0;
  logic        In_Ready;
  logic        IM_Wr;
  logic [6:0]  IM_Addr;
  logic [15:0] IM_Data;
  logic        CPU_Reset;
  logic        Busy;
  logic        Done;
  logic        Err;

  imem_loader dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Len(Len),
    .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .IM_Wr(IM_Wr), .IM_Addr(IM_Addr), .IM_Data(IM_Data),
    .CPU_Reset(CPU_Reset), .Busy(Busy), .Done(Done), .Err(Err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  int  wa_q[$];
  int  wd_q[$];
  int  wc_q[$];
  int  hs_q[$];
  bit  ready_seen;

  logic [15:0] prog [0:127];
  int          gaps [0:128];

  // Write/ready monitor, sampled mid-cycle.
  always @(negedge Clk) begin
    if (IM_Wr) begin
      wa_q.push_back(int'(IM_Addr));
      wd_q.push_back(int'(IM_Data));
      wc_q.push_back(cyc);
    end
    if (In_Ready) ready_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_sum(input int len);
    int s;
    s = 0;
    for (int i = 0; i < len; i++) s = s + int'(prog[i]);
    return 16'(s % 65536);
  endfunction

  task automatic clear_obs();
    wa_q.delete(); wd_q.delete(); wc_q.delete(); hs_q.delete();
    ready_seen = 1'b0;
  endtask

  // Offer one word after 'gap' idle cycles; called at a negedge, returns at one.
  task automatic send_word(input logic [15:0] d, input int gap, input bit is_chk);
    int waited;
    for (int g = 0; g < gap; g++) begin
      In_Valid = 1'b0;
      @(negedge Clk);
    end
    In_Valid = 1'b1;
    In_Data  = d;
    waited = 0;
    while (!In_Ready && waited < 20) begin
      @(negedge Clk);
      waited++;
    end
    check("ready_before_word", In_Ready, 1'b1);
    if (In_Ready) begin
      if (!is_chk) hs_q.push_back(cyc);
      @(negedge Clk);
    end
    In_Valid = 1'b0;
  endtask

  function automatic int pick_gap(input int mode, input int idx);
    if (mode == 1) return int'($urandom_range(0, 2));
    if (mode == 2) return gaps[idx];
    return 0;
  endfunction

  // One complete load of prog[0:len-1] plus checksum, checked against the model.
  task automatic run_load(input string name, input int len, input logic [15:0] chk, input int gap_mode);
    bit legal, ok;
    int exp_wr, n, waited;
    legal  = (len >= 1) && (len <= 128);
    ok     = legal && (chk == ref_sum(len));
    exp_wr = ok ? 128 : (legal ? len : 0);
    clear_obs();
    Start = 1'b1;
    Len   = len[7:0];
    @(negedge Clk);
    Start = 1'b0;
    check($sformatf("%s cpu_reset_held", name), CPU_Reset, 1'b1);
    check($sformatf("%s err_next", name), Err, !legal);
    check($sformatf("%s busy_next", name), Busy, legal);
    if (legal) begin
      check($sformatf("%s done_cleared", name), Done, 1'b0);
      for (int i = 0; i < len; i++) send_word(prog[i], pick_gap(gap_mode, i), 1'b0);
      send_word(chk, pick_gap(gap_mode, len), 1'b1);
    end
    waited = 0;
    while (!(Done || Err) && waited < 400) begin
      @(negedge Clk);
      waited++;
    end
    check($sformatf("%s finished", name), Done || Err, 1'b1);
    repeat (3) @(negedge Clk);
    check($sformatf("%s done", name), Done, ok);
    check($sformatf("%s err", name), Err, !ok);
    check($sformatf("%s cpu_reset", name), CPU_Reset, !ok);
    check($sformatf("%s busy", name), Busy, 1'b0);
    check($sformatf("%s in_ready", name), In_Ready, 1'b0);
    check($sformatf("%s ready_seen", name), ready_seen, legal);
    check($sformatf("%s write_count", name), wa_q.size(), exp_wr);
    n = (wa_q.size() < exp_wr) ? wa_q.size() : exp_wr;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s addr[%0d]", name, i), wa_q[i], i);
      check($sformatf("%s data[%0d]", name, i), wd_q[i], (i < len) ? int'(prog[i]) : 32'h5000);
      if (i < len && i < hs_q.size())
        check($sformatf("%s latency[%0d]", name, i), wc_q[i], hs_q[i] + 1);
      if (i > len)
        check($sformatf("%s fill_nostall[%0d]", name, i), wc_q[i], wc_q[i-1] + 1);
    end
  endtask

  initial begin
    logic [15:0] given [0:8];
    logic [15:0] c;
    int rl;

    given[0] = 16'h21B1; given[1] = 16'h22A2; given[2] = 16'h23C3;
    given[3] = 16'h27E4; given[4] = 16'h4125; given[5] = 16'h3536;
    given[6] = 16'h464A; given[7] = 16'h1A6A; given[8] = 16'h5000;

    // Reset values.
    repeat (3) @(negedge Clk);
    check("rst in_ready", In_Ready, 1'b0);
    check("rst im_wr", IM_Wr, 1'b0);
    check("rst im_addr", IM_Addr, 7'd0);
    check("rst im_data", IM_Data, 16'h0000);
    check("rst cpu_reset", CPU_Reset, 1'b1);
    check("rst busy", Busy, 1'b0);
    check("rst done", Done, 1'b0);
    check("rst err", Err, 1'b0);
    Reset = 1'b0;
    @(negedge Clk);

    // Reference program with random gaps; then the same with a bad checksum.
    for (int i = 0; i < 9; i++) prog[i] = given[i];
    run_load("prog9", 9, 16'hB709, 1);
    run_load("badchk", 9, 16'hB708, 0);

    // Illegal lengths.
    run_load("len0", 0, 16'h0000, 0);
    run_load("len129", 129, 16'h0000, 0);

    // Back-pressure: In_Valid pattern 1,0,0,1,1,1.
    for (int i = 0; i < 3; i++) prog[i] = 16'($urandom);
    gaps[0] = 0; gaps[1] = 2; gaps[2] = 0; gaps[3] = 0;
    run_load("gaps3", 3, ref_sum(3), 2);

    // Full memory: words 0..127, checksum 0x1FC0.
    for (int i = 0; i < 128; i++) prog[i] = 16'(i);
    run_load("full128", 128, 16'h1FC0, 0);

    // Randomized loads, checksum correct or corrupted.
    for (int t = 0; t < 4; t++) begin
      rl = int'($urandom_range(1, 128));
      for (int i = 0; i < rl; i++) prog[i] = 16'($urandom);
      c = ref_sum(rl);
      if ($urandom_range(0, 1) == 1) c = c ^ (16'h0001 << $urandom_range(0, 15));
      run_load($sformatf("rand%0d", t), rl, c, 1);
    end

    // Reset in the middle of LOAD after 4 words, then a fresh short load.
    clear_obs();
    Start = 1'b1;
    Len   = 8'd10;
    @(negedge Clk);
    Start = 1'b0;
    for (int i = 0; i < 4; i++) send_word(16'($urandom), 0, 1'b0);
    Reset = 1'b1;
    @(negedge Clk);
    check("midrst cpu_reset", CPU_Reset, 1'b1);
    check("midrst busy", Busy, 1'b0);
    check("midrst in_ready", In_Ready, 1'b0);
    check("midrst im_wr", IM_Wr, 1'b0);
    check("midrst writes", wa_q.size(), 4);
    Reset = 1'b0;
    @(negedge Clk);
    check("midrst no_more_writes", wa_q.size(), 4);
    prog[0] = 16'($urandom);
    prog[1] = 16'($urandom);
    run_load("after_rst", 2, ref_sum(2), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
